uart_tx_configuravel: RTL and testbench
=======================================

# uart_tx_configuravel

Parametrised UART transmitter with an input FIFO, for use wherever the FPGA design sends sensor data, status bytes or command replies to the host over the serial line. Frame format is fixed at elaboration: data width, parity mode and stop-bit count are parameters. A small FIFO lets upstream logic queue several words, which are then sent back-to-back with no idle gap. A per-frame completion pulse is kept for existing consumers.

## Interface
- `CLOCKS_POR_BIT`, 5209: clock cycles per serial bit, legal range ≥2. The baud counter is `$clog2(CLOCKS_POR_BIT)` bits wide.
- `BITS_DADOS`, 8: data bits per frame, legal range 5–9.
- `MODO_PARIDADE`, 0: 0 = none, 1 = odd, 2 = even.
- `BITS_PARADA`, 1: stop bits, 1 or 2.
- `PROFUNDIDADE_FIFO`, 4: FIFO depth, a power of 2, ≥2.
- Out-of-range parameters are an elaboration-time error.

Ports:
- `clock` input 1: single clock for the block.
- `reset` input 1: synchronous, active-high.
- `dadoEntrada` input `BITS_DADOS`: word to enqueue.
- `escreveDado` input 1: write strobe. The write is accepted on an edge where `escreveDado && !fifoCheia`.
- `fifoCheia` output 1: FIFO holds `PROFUNDIDADE_FIFO` words.
- `fifoVazia` output 1: FIFO holds 0 words.
- `bitSerialAtual` output 1: serial line, registered. Idle level is 1.
- `indicaTransmissao` output 1: a frame is on the line.
- `bitsEstaoEnviados` output 1: one-cycle pulse per completed frame.

## Operation
- **FIFO:** a circular buffer with read and write pointers plus an occupancy count.
  - `fifoCheia` and `fifoVazia` are decoded from the registered count.
  - A write while `fifoCheia` is high is dropped silently and does not change FIFO contents.
  - A write and a pop on the same edge are both performed, and the count is unchanged.
- **FSM states:** ESPERA, INICIO, DADOS, PARIDADE, PARADA.
- **ESPERA:** line is 1.
  - If the FIFO is non-empty, pop the head into the shift register, drive 0 and go to INICIO.
- **INICIO:** hold 0 for `CLOCKS_POR_BIT` cycles, then go to DADOS.
- **DADOS:** send bits LSB first, each for `CLOCKS_POR_BIT` cycles, using a bit index from 0 to `BITS_DADOS`-1.
  - After the last bit, go to PARIDADE if `MODO_PARIDADE`≠0, otherwise go to PARADA.
- **PARIDADE:** the parity bit is computed over the data bits. Even mode sends the XOR of all data bits; odd mode sends its inverse. Hold it for `CLOCKS_POR_BIT` cycles.
- **PARADA:** hold 1 for `BITS_PARADA`×`CLOCKS_POR_BIT` cycles. At the end of the last stop-bit cycle:
  - `bitsEstaoEnviados` pulses for one cycle.
  - If the FIFO is non-empty, pop the next word and enter INICIO directly, with no idle gap.
  - Otherwise return to ESPERA.
- **indicaTransmissao:** high from the first start-bit cycle through the last stop-bit cycle. It stays high continuously across back-to-back frames.
- **Undefined state:** an unused state encoding returns to ESPERA with the line at 1.

## Timing
- **Reset values:**
  - `bitSerialAtual`=1, `indicaTransmissao`=0, `bitsEstaoEnviados`=0.
  - `fifoVazia`=1, `fifoCheia`=0.
  - FIFO pointers and count = 0, FSM in ESPERA.
- **Reset mid-frame:** aborts the frame. The line is 1 after the reset edge, queued words are discarded and no completion pulse is produced.
- **Latency:**
  - A word written on edge k into an empty FIFO sets `fifoVazia`=0 after edge k.
  - If the FSM is in ESPERA, the start bit begins after edge k+1 and `fifoVazia` returns to 1.
- **Frame length:** `CLOCKS_POR_BIT`×(1+`BITS_DADOS`+P+`BITS_PARADA`) cycles, where P=1 if parity is enabled and 0 otherwise.
  - Every bit lasts exactly `CLOCKS_POR_BIT` cycles.
- **Completion pulse:** `bitsEstaoEnviados` is high in the first cycle after the final stop-bit cycle, for exactly one cycle.
  - That cycle is also the first cycle of the next start bit when frames are back-to-back.
- **Parity source:** parity is computed from the popped word held in the shift register. Writes during a frame never alter the frame in flight.

## Test plan
Bench uses `CLOCKS_POR_BIT`=4.
- **8N1, 0x55:** write 0x55 while idle -> line reads 0, then 1,0,1,0,1,0,1,0, then 1, each for 4 cycles (40 cycles total). Start bit begins 1 cycle after the write edge. One `bitsEstaoEnviados` pulse follows; `indicaTransmissao` is high for exactly 40 cycles.
- **7 bits, 2 stop, 0x41:** even parity -> data 1,0,0,0,0,0,1, parity 0, stop 1,1, frame 44 cycles. Odd parity -> parity bit 1.
- **9 bits, odd parity, 0x1FF:** nine 1s, then parity 0, then stop 1, frame 48 cycles.
- **FIFO overflow:** depth 4, idle; write W0..W5 on 6 consecutive edges -> `fifoCheia` rises after the W4 write and W5 is dropped. W0..W4 are sent back-to-back with no idle cycles, with 5 completion pulses, 40 cycles apart. `fifoVazia`=1 once W4 is popped.
- **Simultaneous write and pop:** write a word on the same edge the FSM pops the last queued word at the end of a stop bit -> the count is unchanged and both words are transmitted in order.
- **Reset mid-data:** assert `reset` during data bit 3 with 2 words queued -> the next cycle shows line=1, `indicaTransmissao`=0 and `fifoVazia`=1. No pulse is produced and nothing is transmitted afterwards.

Source files
------------

// File: rtl/uart_tx_configuravel_if.sv
// Bus between an upstream word producer and uart_tx_configuravel.
//   master : producer side. Drives dadoEntrada/escreveDado and observes the status and serial outputs.
//   slave  : transmitter side. Accepts words and drives the FIFO flags, the serial line and the frame status.
interface uart_tx_configuravel_if #(
    parameter int BITS_DADOS = 8
);
    logic [BITS_DADOS-1:0] dadoEntrada;
    logic                  escreveDado;
    logic                  fifoCheia;
    logic                  fifoVazia;
    logic                  bitSerialAtual;
    logic                  indicaTransmissao;
    logic                  bitsEstaoEnviados;

    modport master (
        output dadoEntrada, escreveDado,
        input  fifoCheia, fifoVazia, bitSerialAtual, indicaTransmissao, bitsEstaoEnviados
    );

    modport slave (
        input  dadoEntrada, escreveDado,
        output fifoCheia, fifoVazia, bitSerialAtual, indicaTransmissao, bitsEstaoEnviados
    );
endinterface

// File: rtl/uart_tx_configuravel.sv
// UART transmitter with an input FIFO. The frame format is fixed by parameters:
// start bit, BITS_DADOS data bits sent LSB first, optional parity, and 1 or 2 stop bits.
// Queued words go out back-to-back with no idle gap between frames.
// Ports:
//   clock, reset                 : single clock; reset is synchronous and active-high
//   bus.dadoEntrada/escreveDado  : word enqueue, accepted when escreveDado && !fifoCheia
//   bus.fifoCheia/fifoVazia      : FIFO full/empty, decoded from the registered count
//   bus.bitSerialAtual           : registered serial line, idles at 1
//   bus.indicaTransmissao        : high while a frame is on the line
//   bus.bitsEstaoEnviados        : one-cycle pulse after each frame's final stop-bit cycle
module uart_tx_configuravel #(
    parameter int CLOCKS_POR_BIT    = 5209,
    parameter int BITS_DADOS        = 8,
    parameter int MODO_PARIDADE     = 0,
    parameter int BITS_PARADA       = 1,
    parameter int PROFUNDIDADE_FIFO = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_tx_configuravel_if.slave bus
);
    if (CLOCKS_POR_BIT < 2 || BITS_DADOS < 5 || BITS_DADOS > 9 ||
        MODO_PARIDADE < 0 || MODO_PARIDADE > 2 ||
        (BITS_PARADA != 1 && BITS_PARADA != 2) || PROFUNDIDADE_FIFO < 2 ||
        (PROFUNDIDADE_FIFO & (PROFUNDIDADE_FIFO - 1)) != 0) begin : g_parametro_invalido
        $error("uart_tx_configuravel: parameter out of range");
    end

    localparam int CW = $clog2(CLOCKS_POR_BIT);
    localparam int IW = $clog2(BITS_DADOS);
    localparam int PW = $clog2(PROFUNDIDADE_FIFO);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX       = CW'(CLOCKS_POR_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX       = IW'(BITS_DADOS - 1);
    localparam logic [NW-1:0] CONTA_CHEIA   = NW'(PROFUNDIDADE_FIFO);
    localparam logic          ULTIMA_PARADA = (BITS_PARADA == 2);

    typedef enum logic [2:0] {ESPERA, INICIO, DADOS, PARIDADE, PARADA} estado_t;

    // FIFO storage and bookkeeping
    logic [BITS_DADOS-1:0] mem_q [PROFUNDIDADE_FIFO];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]         count_q, count_d;
    logic                  cheia, vazia, push, pop;
    logic [BITS_DADOS-1:0] cabeca;

    // Transmit state
    estado_t               estado_q, estado_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  parada_q, parada_d;
    logic [BITS_DADOS-1:0] shift_q, shift_d;
    logic                  serial_q, serial_d;
    logic                  tx_q, tx_d;
    logic                  pulso_q, pulso_d;
    logic                  fim_bit, bit_paridade;

    assign cheia  = (count_q == CONTA_CHEIA);
    assign vazia  = (count_q == '0);
    assign push   = bus.escreveDado && !cheia;
    assign cabeca = mem_q[rd_ptr_q];

    assign fim_bit      = (cnt_q == CNT_MAX);
    assign bit_paridade = (MODO_PARIDADE == 2) ? ^shift_q : ~(^shift_q);

    assign bus.fifoCheia         = cheia;
    assign bus.fifoVazia         = vazia;
    assign bus.bitSerialAtual    = serial_q;
    assign bus.indicaTransmissao = tx_q;
    assign bus.bitsEstaoEnviados = pulso_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        parada_d = parada_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        tx_d     = tx_q;
        pulso_d  = 1'b0;
        pop      = 1'b0;
        case (estado_q)
            ESPERA: begin
                serial_d = 1'b1;
                tx_d     = 1'b0;
                if (!vazia) begin
                    pop      = 1'b1;
                    shift_d  = cabeca;
                    serial_d = 1'b0;
                    tx_d     = 1'b1;
                    cnt_d    = '0;
                    estado_d = INICIO;
                end
            end
            INICIO: begin
                if (fim_bit) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    estado_d = DADOS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DADOS: begin
                if (fim_bit) begin
                    cnt_d = '0;
                    if (idx_q == IDX_MAX) begin
                        if (MODO_PARIDADE != 0) begin
                            serial_d = bit_paridade;
                            estado_d = PARIDADE;
                        end else begin
                            serial_d = 1'b1;
                            parada_d = 1'b0;
                            estado_d = PARADA;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        serial_d = shift_q[idx_q + 1'b1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARIDADE: begin
                if (fim_bit) begin
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    parada_d = 1'b0;
                    estado_d = PARADA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARADA: begin
                if (fim_bit) begin
                    cnt_d = '0;
                    if (parada_q == ULTIMA_PARADA) begin
                        pulso_d = 1'b1;
                        // Chain straight into the next start bit so queued words leave no idle gap.
                        if (!vazia) begin
                            pop      = 1'b1;
                            shift_d  = cabeca;
                            serial_d = 1'b0;
                            estado_d = INICIO;
                        end else begin
                            serial_d = 1'b1;
                            tx_d     = 1'b0;
                            estado_d = ESPERA;
                        end
                    end else begin
                        parada_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                serial_d = 1'b1;
                tx_d     = 1'b0;
                cnt_d    = '0;
                estado_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            estado_q <= ESPERA;
            cnt_q    <= '0;
            idx_q    <= '0;
            parada_q <= 1'b0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            tx_q     <= 1'b0;
            pulso_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            parada_q <= parada_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            tx_q     <= tx_d;
            pulso_q  <= pulso_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.dadoEntrada;
    end
endmodule

// File: tb/tb_uart_tx_configuravel.sv
// Bench for uart_tx_configuravel: four frame formats run side by side, each against a
// queue-based model that expands every popped word into its per-cycle line waveform.
module tb_uart_tx_configuravel;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NCFG  = 4;

    typedef bit bitq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [NCFG-1:0] done;

    function automatic int cfg_nb(input int g);
        case (g) 0: return 8; 1: return 7; 2: return 7; default: return 9; endcase
    endfunction
    function automatic int cfg_par(input int g);
        case (g) 0: return 0; 1: return 2; 2: return 1; default: return 1; endcase
    endfunction
    function automatic int cfg_stop(input int g);
        case (g) 0: return 1; 1: return 2; 2: return 2; default: return 1; endcase
    endfunction
    function automatic int cfg_word(input int g);
        case (g) 0: return 'h55; 1: return 'h41; 2: return 'h41; default: return 'h1FF; endcase
    endfunction
    // Hand-written frames, bit i = i-th bit on the line (start bit first).
    function automatic logic [15:0] cfg_lit(input int g);
        case (g) 0: return 16'h02AA; 1: return 16'h0682; 2: return 16'h0782; default: return 16'h0BFE; endcase
    endfunction
    function automatic int cfg_len(input int g);
        case (g) 0: return 10; 1: return 11; 2: return 11; default: return 12; endcase
    endfunction
    function automatic int cfg_cycles(input int g);
        case (g) 0: return 40; 1: return 44; 2: return 44; default: return 48; endcase
    endfunction

    // Sequence of line bits for one word: start, data LSB first, optional parity, stop bits.
    function automatic bitq_t build_frame(input logic [8:0] w, input int nb, input int pm, input int ns);
        bitq_t s;
        bit p;
        p = 1'b0;
        s.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            s.push_back(w[i]);
            p = p ^ w[i];
        end
        if (pm == 1) s.push_back(~p);
        else if (pm == 2) s.push_back(p);
        for (int i = 0; i < ns; i++) s.push_back(1'b1);
        return s;
    endfunction

    function automatic logic [15:0] pack(input bitq_t s);
        logic [15:0] v;
        v = '0;
        foreach (s[i]) v[i] = s[i];
        return v;
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cfg%0d t=%0t: got %0h, required %0h", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int NB    = cfg_nb(g);
        localparam int PM    = cfg_par(g);
        localparam int NS    = cfg_stop(g);
        localparam int FRAME = cfg_cycles(g);

        logic rst;
        logic chk_en;
        logic done_g;
        logic [NB-1:0] mq[$];
        bit fb[$];
        bit m_pulse;

        assign done[g] = done_g;

        uart_tx_configuravel_if #(.BITS_DADOS(NB)) bus ();

        uart_tx_configuravel #(
            .CLOCKS_POR_BIT   (CPB),
            .BITS_DADOS       (NB),
            .MODO_PARIDADE    (PM),
            .BITS_PARADA      (NS),
            .PROFUNDIDADE_FIFO(DEPTH)
        ) dut (
            .clock(clk),
            .reset(rst),
            .bus  (bus)
        );

        initial begin : model
            bitq_t bits;
            int unsigned qsz;
            logic [NB-1:0] w;
            m_pulse = 1'b0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    mq.delete();
                    fb.delete();
                    m_pulse = 1'b0;
                end else begin
                    qsz = mq.size();
                    m_pulse = (fb.size() == 1);
                    if (fb.size() > 0) fb.delete(0);
                    if (fb.size() == 0 && qsz > 0) begin
                        w = mq.pop_front();
                        bits = build_frame(9'(w), NB, PM, NS);
                        foreach (bits[i])
                            for (int c = 0; c < CPB; c++) fb.push_back(bits[i]);
                    end
                    if (bus.escreveDado && qsz < DEPTH) mq.push_back(bus.dadoEntrada);
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check("line", g, 32'(bus.bitSerialAtual), 32'((fb.size() > 0) ? fb[0] : 1'b1));
                check("busy", g, 32'(bus.indicaTransmissao), 32'(fb.size() > 0));
                check("done_pulse", g, 32'(bus.bitsEstaoEnviados), 32'(m_pulse));
                check("empty", g, 32'(bus.fifoVazia), 32'(mq.size() == 0));
                check("full", g, 32'(bus.fifoCheia), 32'(mq.size() == DEPTH));
            end
        end

        initial begin : stim
            bitq_t ref_bits;
            logic [15:0] lit;
            logic [5:0] full_hist;
            int tx_cycles, pulses, gaps, first_pulse, last_pulse, bad_spacing;
            done_g = 1'b0;
            chk_en = 1'b0;
            rst = 1'b1;
            bus.escreveDado = 1'b0;
            bus.dadoEntrada = '0;
            repeat (3) @(negedge clk);
            check("reset_line", g, 32'(bus.bitSerialAtual), 32'(1));
            check("reset_busy", g, 32'(bus.indicaTransmissao), 32'(0));
            check("reset_empty", g, 32'(bus.fifoVazia), 32'(1));
            check("reset_full", g, 32'(bus.fifoCheia), 32'(0));
            rst = 1'b0;
            chk_en = 1'b1;

            // Pin the model's frame builder to the hand-written frames.
            ref_bits = build_frame(9'(cfg_word(g)), NB, PM, NS);
            check("model_frame", g, 32'(pack(ref_bits)), 32'(cfg_lit(g)));
            check("model_len", g, 32'(ref_bits.size() * CPB), 32'(cfg_cycles(g)));

            // Single literal frame from idle.
            bus.dadoEntrada = NB'(cfg_word(g));
            bus.escreveDado = 1'b1;
            @(negedge clk);
            bus.escreveDado = 1'b0;
            check("empty_after_write", g, 32'(bus.fifoVazia), 32'(0));
            check("line_before_start", g, 32'(bus.bitSerialAtual), 32'(1));
            @(negedge clk);
            check("start_latency", g, 32'(bus.bitSerialAtual), 32'(0));
            check("empty_after_pop", g, 32'(bus.fifoVazia), 32'(1));
            lit = cfg_lit(g);
            tx_cycles = 0;
            pulses = 0;
            for (int c = 0; c < FRAME + 8; c++) begin
                if (bus.indicaTransmissao) tx_cycles++;
                if (bus.bitsEstaoEnviados) pulses++;
                if (c % CPB == 0 && c < cfg_len(g) * CPB)
                    check("frame_bit", g, 32'(bus.bitSerialAtual), 32'(lit[c / CPB]));
                @(negedge clk);
            end
            check("frame_cycles", g, 32'(tx_cycles), 32'(cfg_cycles(g)));
            check("frame_pulses", g, 32'(pulses), 32'(1));

            // Overflow: six writes on consecutive edges from idle; the sixth is dropped.
            for (int i = 0; i < 6; i++) begin
                bus.dadoEntrada = NB'($urandom);
                bus.escreveDado = 1'b1;
                @(negedge clk);
                full_hist[i] = bus.fifoCheia;
            end
            bus.escreveDado = 1'b0;
            check("full_history", g, 32'(full_hist), 32'(6'b110000));
            pulses = 0;
            gaps = 0;
            first_pulse = -1;
            last_pulse = -1;
            bad_spacing = 0;
            for (int c = 0; c < 5 * FRAME + 20; c++) begin
                if (bus.bitsEstaoEnviados) begin
                    if (first_pulse < 0) first_pulse = c;
                    else if (c - last_pulse != FRAME) bad_spacing++;
                    last_pulse = c;
                    pulses++;
                end
                if (pulses < 5 && !bus.indicaTransmissao) gaps++;
                @(negedge clk);
            end
            check("burst_pulses", g, 32'(pulses), 32'(5));
            check("burst_gaps", g, 32'(gaps), 32'(0));
            check("burst_first_pulse", g, 32'(first_pulse), 32'(cfg_cycles(g) - 4));
            check("burst_spacing", g, 32'(bad_spacing), 32'(0));

            // Write on the very edge that pops the last queued word.
            bus.dadoEntrada = NB'($urandom);
            bus.escreveDado = 1'b1;
            @(negedge clk);
            bus.dadoEntrada = NB'($urandom);
            @(negedge clk);
            bus.escreveDado = 1'b0;
            repeat (FRAME - 1) @(negedge clk);
            bus.dadoEntrada = NB'($urandom);
            bus.escreveDado = 1'b1;
            @(negedge clk);
            bus.escreveDado = 1'b0;
            check("simul_pulse", g, 32'(bus.bitsEstaoEnviados), 32'(1));
            check("simul_start", g, 32'(bus.bitSerialAtual), 32'(0));
            check("simul_count_kept", g, 32'(bus.fifoVazia), 32'(0));
            repeat (2 * FRAME + 10) @(negedge clk);

            // Reset during data bit 3 with two words queued.
            bus.escreveDado = 1'b1;
            for (int i = 0; i < 3; i++) begin
                bus.dadoEntrada = NB'($urandom);
                @(negedge clk);
            end
            bus.escreveDado = 1'b0;
            repeat (4 * CPB - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_line", g, 32'(bus.bitSerialAtual), 32'(1));
            check("abort_busy", g, 32'(bus.indicaTransmissao), 32'(0));
            check("abort_empty", g, 32'(bus.fifoVazia), 32'(1));
            pulses = 0;
            tx_cycles = 0;
            for (int c = 0; c < 3 * FRAME; c++) begin
                if (bus.bitsEstaoEnviados) pulses++;
                if (bus.indicaTransmissao || !bus.bitSerialAtual) tx_cycles++;
                @(negedge clk);
            end
            check("abort_no_pulse", g, 32'(pulses), 32'(0));
            check("abort_silent", g, 32'(tx_cycles), 32'(0));

            // Random traffic with occasional resets.
            for (int c = 0; c < 1500; c++) begin
                bus.escreveDado = ($urandom_range(0, 9) < 2);
                bus.dadoEntrada = NB'($urandom);
                rst = ($urandom_range(0, 599) == 0);
                @(negedge clk);
            end
            bus.escreveDado = 1'b0;
            rst = 1'b0;
            repeat ((DEPTH + 1) * FRAME + 4) @(negedge clk);
            check("drained_empty", g, 32'(bus.fifoVazia), 32'(1));
            check("drained_idle", g, 32'(bus.indicaTransmissao), 32'(0));
            done_g = 1'b1;
        end
    end

    initial begin : main
        for (int c = 0; c < 40000 && !(&done); c++) @(negedge clk);
        if (!(&done)) begin
            miscompares++;
            $display("FAIL timeout: done=%b, required %b", done, {NCFG{1'b1}});
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
